// File: rtl/eq_seq_pkg.sv
// Shared definitions for the sequential equality arbiter.
//   ST_IDLE/ST_CMP/ST_DONE : FSM state encodings
//   NREQ                   : number of requesters sharing the slice
//   state_t                : FSM state type built on the encodings above
//   onehot()               : requester id -> one-hot grant vector
package eq_seq_pkg;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_CMP  = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;

   localparam int NREQ = 2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      CMP  = ST_CMP,
      DONE = ST_DONE
   } state_t;

   function automatic logic [NREQ-1:0] onehot(input logic id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/eq2_slice.sv
// Combinational 2-bit equality slice; the single shared compare resource.
//   a, b : 2-bit operand slices
//   eq   : 1 when a == b
module eq2_slice (
   input  logic [1:0] a,
   input  logic [1:0] b,
   output logic       eq
);

   assign eq = (a == b);

endmodule

// File: rtl/eq_seq_arbiter.sv
// Two requesters share one 2-bit equality slice. Round-robin arbitration picks
// a winner, its operands are latched and compared 2 bits per clock from the
// LSB, stopping early on the first mismatching slice.
//   clk       : system clock, rising edge
//   reset_n   : asynchronous active-low reset
//   req       : level request per requester
//   a_bus     : operand A, requester i on [i*W +: W]
//   b_bus     : operand B, same packing
//   gnt       : one-hot grant, asserted through CMP and DONE
//   done_tick : one-cycle result strobe
//   aeqb      : comparison result, held until next done_tick
//   owner     : requester id of the last completed comparison, held
module eq_seq_arbiter
   import eq_seq_pkg::*;
#(
   parameter int W  = 8,
   parameter int CW = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] a_bus,
   input  logic [NREQ*W-1:0] b_bus,
   output logic [NREQ-1:0]   gnt,
   output logic              done_tick,
   output logic              aeqb,
   output logic              owner
);

   state_t         state;
   logic [W-1:0]   sa, sb;
   logic [CW-1:0]  cnt;
   logic           cur;         // requester currently being served
   logic           last_grant;  // requester served most recently
   logic           win;
   logic           slice_eq;

   // On a tie the requester that did not win last time gets the slice.
   always_comb begin
      win = 1'b0;
      case (req)
         2'b01:   win = 1'b0;
         2'b10:   win = 1'b1;
         2'b11:   win = ~last_grant;
         default: win = 1'b0;
      endcase
   end

   eq2_slice u_slice (
      .a  (sa[1:0]),
      .b  (sb[1:0]),
      .eq (slice_eq)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         sa         <= '0;
         sb         <= '0;
         cnt        <= '0;
         cur        <= 1'b0;
         last_grant <= 1'b1;
         gnt        <= '0;
         done_tick  <= 1'b0;
         aeqb       <= 1'b0;
         owner      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req != '0) begin
                  sa    <= win ? a_bus[2*W-1:W] : a_bus[W-1:0];
                  sb    <= win ? b_bus[2*W-1:W] : b_bus[W-1:0];
                  cur   <= win;
                  gnt   <= onehot(win);
                  cnt   <= '0;
                  state <= CMP;
               end
            end
            CMP: begin
               // Result, owner and strobe are loaded on the way into DONE so
               // they are visible as registered outputs during DONE itself.
               if (!slice_eq) begin
                  aeqb      <= 1'b0;
                  owner     <= cur;
                  done_tick <= 1'b1;
                  state     <= DONE;
               end else if (cnt == CW'(W/2-1)) begin
                  aeqb      <= 1'b1;
                  owner     <= cur;
                  done_tick <= 1'b1;
                  state     <= DONE;
               end else begin
                  sa  <= sa >> 2;
                  sb  <= sb >> 2;
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               last_grant <= cur;
               done_tick  <= 1'b0;
               gnt        <= '0;
               state      <= IDLE;
            end
            default: begin
               state <= IDLE;
               gnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_eq_seq_arbiter.sv
module tb_eq_seq_arbiter;

   localparam int W = 8;

   logic           clk = 1'b0;
   logic           reset_n = 1'b1;
   logic [1:0]     req = 2'b00;
   logic [2*W-1:0] a_bus = '0;
   logic [2*W-1:0] b_bus = '0;
   logic [1:0]     gnt;
   logic           done_tick, aeqb, owner;

   eq_seq_arbiter #(.W(W), .CW(3)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .a_bus(a_bus), .b_bus(b_bus),
      .gnt(gnt), .done_tick(done_tick), .aeqb(aeqb), .owner(owner)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   typedef struct {
      logic aeqb;
      logic owner;
      int   at;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input logic e_aeqb, input logic e_owner, input int at);
      exp_t e;
      e.aeqb  = e_aeqb;
      e.owner = e_owner;
      e.at    = at;
      sb_q.push_back(e);
   endtask

   task automatic set_ops(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
      a_bus[id*W +: W] = a;
      b_bus[id*W +: W] = b;
   endtask

   // Waits for every expected result to be reported, bounded.
   task automatic drain();
      for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
      chk("drain_pending", sb_q.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   // Monitor: pops an expectation for every done_tick, and watches gnt.
   initial forever begin
      exp_t e;
      @(negedge clk);
      chk("gnt_not_twohot", int'(gnt == 2'b11), 0);
      if (done_tick === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_done: got done_tick at cycle %0d expected none", cyc);
         end else begin
            e = sb_q.pop_front();
            chk("aeqb", int'(aeqb), int'(e.aeqb));
            chk("owner", int'(owner), int'(e.owner));
            chk("done_cycle", cyc, e.at);
         end
      end
   end

   int t0;

   initial begin
      // reset state
      #1 reset_n = 1'b0;
      @(negedge clk);
      chk("rst_gnt", int'(gnt), 0);
      chk("rst_done", int'(done_tick), 0);
      chk("rst_aeqb", int'(aeqb), 0);
      chk("rst_owner", int'(owner), 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // equal operands, requester 0
      t0 = cyc;
      set_ops(0, 8'hA5, 8'hA5);
      req = 2'b01;
      push(1'b1, 1'b0, t0 + 5);
      @(negedge clk);
      chk("eq_gnt_c1", int'(gnt), 1);
      req = 2'b00;
      drain();

      // LSB mismatch, requester 1
      t0 = cyc;
      set_ops(1, 8'hA5, 8'hA4);
      req = 2'b10;
      push(1'b0, 1'b1, t0 + 2);
      @(negedge clk);
      chk("lsb_gnt_c1", int'(gnt), 2);
      req = 2'b00;
      @(negedge clk);
      chk("lsb_gnt_c2", int'(gnt), 2);
      @(negedge clk);
      chk("lsb_gnt_c3", int'(gnt), 0);
      drain();

      // MSB-slice mismatch; operand change mid-compare must be ignored
      t0 = cyc;
      set_ops(0, 8'h25, 8'hA5);
      req = 2'b01;
      push(1'b0, 1'b0, t0 + 5);
      @(negedge clk);
      req = 2'b00;
      @(negedge clk);
      set_ops(0, 8'h25, 8'h25);
      drain();

      // lone requester held: granted back-to-back
      t0 = cyc;
      set_ops(0, 8'h01, 8'h00);
      req = 2'b01;
      push(1'b0, 1'b0, t0 + 2);
      push(1'b0, 1'b0, t0 + 5);
      repeat (4) @(negedge clk);
      req = 2'b00;
      drain();

      // mid-run reset, then contention: tie goes to 0 first, then alternates
      reset_n = 1'b0;
      #1;
      chk("rst2_gnt", int'(gnt), 0);
      chk("rst2_aeqb", int'(aeqb), 0);
      chk("rst2_owner", int'(owner), 0);
      @(negedge clk);
      reset_n = 1'b1;
      t0 = cyc;
      set_ops(0, 8'h3C, 8'h3C);
      set_ops(1, 8'hC3, 8'hC3);
      req = 2'b11;
      push(1'b1, 1'b0, t0 + 5);
      push(1'b1, 1'b1, t0 + 11);
      push(1'b1, 1'b0, t0 + 17);
      push(1'b1, 1'b1, t0 + 23);
      repeat (19) @(negedge clk);
      req = 2'b00;
      drain();

      // reset during CMP: grant drops at once, no result reported
      t0 = cyc;
      set_ops(0, 8'h5A, 8'h5A);
      req = 2'b01;
      @(negedge clk);
      req = 2'b00;
      @(negedge clk);
      chk("midcmp_gnt_c2", int'(gnt), 1);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("midcmp_gnt_rst", int'(gnt), 0);
      chk("midcmp_done_rst", int'(done_tick), 0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("final_queue", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/eq_seq_arbiter.md
Name: eq_seq_arbiter

Overview:
- Shares one 2-bit equality slice between two requesters.
- Each requester asks for a comparison of two W-bit operands; the block arbitrates round-robin and latches the winner's operands.
- It compares them serially, 2 bits per clock from LSB, with early termination on mismatch.
- It returns a one-cycle done tick with the result and the id of the requester served.

Parameters:
- W, 8, operand width in bits; must be even and >= 2.
- CW, 3, slice counter width; must satisfy 2^CW >= W/2.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  2  level request per requester; bit i = requester i.
- a_bus  in  2*W  operand A; requester i drives bits [i*W +: W].
- b_bus  in  2*W  operand B; same packing as a_bus.
- gnt  out  2  one-hot grant; all-zero when idle.
- done_tick  out  1  one-cycle pulse when a result is valid.
- aeqb  out  1  comparison result; held until next done_tick.
- owner  out  1  requester id of the last completed comparison; held.

Behaviour:
- Reset (asynchronous, any state, including mid-comparison):
  - state=IDLE; gnt=00, done_tick=0, aeqb=0, owner=0.
  - last_grant=1, so requester 0 wins the first tie.
  - Shift registers and counter are cleared.
  - An interrupted comparison produces no done_tick.
- All outputs are registered.
- States: IDLE, CMP, DONE.
- IDLE:
  - If req==00, stay in IDLE.
  - Otherwise pick a winner:
    - Only one bit set: that requester wins.
    - Both bits set: the requester != last_grant wins.
  - On the next edge: latch the winner's A and B into shift registers sa and sb; gnt=onehot(winner); cnt=0; go to CMP.
- CMP, evaluated every cycle:
  - Slice compare: e = (sa[1:0]==sb[1:0]) through the shared slice.
  - If e==0: aeqb<=0, go to DONE (early termination).
  - Else if cnt==W/2-1: aeqb<=1, go to DONE.
  - Else: shift sa and sb right by 2, cnt<=cnt+1.
- DONE, one cycle:
  - done_tick=1; owner=winner; last_grant<=winner.
  - gnt is still asserted this cycle.
  - Next edge: gnt<=00, go to IDLE.
- Latency, counting the cycle IDLE samples req as cycle 0:
  - Equal operands: DONE in cycle W/2+1 (cycle 5 for W=8).
  - First mismatching pair at slice k (0 = LSB): DONE in cycle k+2.
- Minimum spacing between consecutive done_tick pulses: 3 cycles (IDLE, CMP, DONE).
- Operand changes after the latch are ignored.
- req deasserted during CMP or DONE: the comparison still completes and is reported.
- A requester that keeps req high after DONE is re-arbitrated in IDLE.
- With both requesters held high, grants strictly alternate.
- A lone requester may be granted back-to-back.
- W=2: exactly one CMP cycle.
- gnt is never two-hot; it is nonzero only in CMP and DONE.

Decomposition:
- Shared package eq_seq_pkg:
  - state encoding localparams ST_IDLE=2'b00, ST_CMP=2'b01, ST_DONE=2'b10;
  - requester-count constant NREQ=2.
- Sub-module eq2_slice:
  - purely combinational 2-bit equality; inputs a[1:0], b[1:0]; output eq.
  - Instantiated once; it is the shared resource being scheduled.
- Arbiter, FSM, shift registers and counter live in eq_seq_arbiter.

Test Plan:
- Reset check: assert reset_n=0 mid-run, then release -> gnt=00, done_tick=0, aeqb=0, owner=0; first two-way tie grants requester 0.
- Equal operands: W=8, req=01, A0=8'hA5, B0=8'hA5 -> gnt=01 from cycle 1; done_tick in cycle 5; aeqb=1, owner=0.
- LSB mismatch: req=10, A1=8'hA5, B1=8'hA4 -> done_tick in cycle 2; aeqb=0, owner=1; gnt=10 for cycles 1-2 only.
- MSB mismatch plus operand change: A0=8'h25, B0=8'hA5; change B0 to 8'h25 during CMP -> done in cycle 5 with aeqb=0 (latched operands were used).
- Contention: req=11 held with equal operands -> owner sequence 0,1,0,1; done_tick every 6 cycles; gnt never 11.
- Reset mid-CMP: pulse reset_n low in cycle 3 of a comparison -> gnt=00 immediately; no done_tick for that request.
